store_buffer: RTL

- Posted-write buffer between the core's memory stage and the single-ported data memory; owns the data memory port (`we`, 10-bit word address, write data, combinational read data).
- Stores are queued in a FIFO and retire to memory one per cycle whenever the port is not needed by a load, so a store costs the core no stall unless the FIFO is full.
- Loads read memory combinationally in the same cycle, with forwarding from buffered stores that have not yet retired.

---
 rtl/store_buffer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// store_buffer
//   Posted-write buffer sitting between the core's memory stage and a
//   single-ported data memory. Stores are queued and retired one per cycle
//   whenever the memory port is not claimed by a load. Loads read memory
//   combinationally and are forwarded from buffered stores that have not
//   yet reached memory.
//
// Ports
//   clock, reset        system clock; synchronous active-high reset
//   st_valid/st_ready   store handshake; st_addr/st_data store payload
//   ld_valid/ld_addr    load request; ld_data is the same-cycle result
//   mem_we/mem_addr/
//   mem_wd/mem_rd       data memory port (mem_rd combinational on mem_addr)
//   empty, count        buffer occupancy status
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 10
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [AW-1:0]            st_addr,
    input  logic [31:0]              st_data,
    input  logic                     ld_valid,
    input  logic [AW-1:0]            ld_addr,
    output logic [31:0]              ld_data,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_addr,
    output logic [31:0]              mem_wd,
    input  logic [31:0]              mem_rd,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] addr_q [DEPTH];
    logic [AW-1:0] addr_d [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          push;
    logic          drain;
    logic          fwd_hit;
    logic [31:0]   fwd_data;
    logic [PW-1:0] idx;

    // Port arbitration: a load always owns the memory port; otherwise the
    // oldest buffered store retires. Reset suppresses both stores and writes.
    always_comb begin
        st_ready = !reset && !ld_valid && (count_q < FULL);
        push     = st_valid && st_ready;
        drain    = !reset && !ld_valid && (count_q != '0);
        mem_we   = drain;
        mem_addr = '0;
        mem_wd   = '0;
        if (ld_valid) begin
            mem_addr = ld_addr;
        end else if (drain) begin
            mem_addr = addr_q[head_q];
            mem_wd   = data_q[head_q];
        end
    end

    // Forwarding: walk live entries from oldest to youngest so that the
    // last match seen is the youngest store to that word.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_q[idx] == ld_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
        ld_data = '0;
        if (ld_valid) begin
            ld_data = fwd_hit ? fwd_data : mem_rd;
        end
    end

    // Next-state for pointers, occupancy and the entry array. Pointers are
    // exactly PW bits wide so they wrap modulo DEPTH on their own; full and
    // empty are told apart only by the occupancy counter.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (push) begin
            addr_d[tail_q] = st_addr;
            data_d[tail_q] = st_data;
            tail_d         = tail_q + 1'b1;
        end
        if (drain) begin
            head_d = head_q + 1'b1;
        end
        case ({push, drain})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state is reset; stale entries are harmless once count is zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    assign empty = (count_q == '0);
    assign count = count_q;

endmodule
